// File: rtl/cpl_write_engine_if.sv
// Bundle of every handshake/bus signal around the completion write engine.
// The master modport is the engine's view; slave is the view of its peers (mux, queue manager, DMA).
interface cpl_write_engine_if #(
  parameter int SELECT_WIDTH      = 2,
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int REQ_TAG_WIDTH     = 7,
  parameter int OP_TAG_WIDTH      = 8,
  parameter int DMA_ADDR_WIDTH    = 64,
  parameter int CPL_SIZE          = 32
);
  logic [SELECT_WIDTH-1:0]      s_axis_req_sel;
  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_req_queue;
  logic [REQ_TAG_WIDTH-1:0]     s_axis_req_tag;
  logic [CPL_SIZE*8-1:0]        s_axis_req_data;
  logic                         s_axis_req_valid;
  logic                         s_axis_req_ready;

  logic [REQ_TAG_WIDTH-1:0]     m_axis_req_status_tag;
  logic                         m_axis_req_status_full;
  logic                         m_axis_req_status_error;
  logic                         m_axis_req_status_valid;

  logic [SELECT_WIDTH-1:0]      m_axis_cpl_enqueue_req_sel;
  logic [QUEUE_INDEX_WIDTH-1:0] m_axis_cpl_enqueue_req_queue;
  logic [REQ_TAG_WIDTH-1:0]     m_axis_cpl_enqueue_req_tag;
  logic                         m_axis_cpl_enqueue_req_valid;
  logic                         m_axis_cpl_enqueue_req_ready;

  logic [DMA_ADDR_WIDTH-1:0]    s_axis_cpl_enqueue_resp_addr;
  logic [REQ_TAG_WIDTH-1:0]     s_axis_cpl_enqueue_resp_tag;
  logic [OP_TAG_WIDTH-1:0]      s_axis_cpl_enqueue_resp_op_tag;
  logic                         s_axis_cpl_enqueue_resp_full;
  logic                         s_axis_cpl_enqueue_resp_error;
  logic                         s_axis_cpl_enqueue_resp_valid;
  logic                         s_axis_cpl_enqueue_resp_ready;

  logic [OP_TAG_WIDTH-1:0]      m_axis_cpl_enqueue_commit_op_tag;
  logic                         m_axis_cpl_enqueue_commit_valid;
  logic                         m_axis_cpl_enqueue_commit_ready;

  logic [DMA_ADDR_WIDTH-1:0]    m_axis_dma_write_desc_addr;
  logic [CPL_SIZE*8-1:0]        m_axis_dma_write_desc_data;
  logic [REQ_TAG_WIDTH-1:0]     m_axis_dma_write_desc_tag;
  logic                         m_axis_dma_write_desc_valid;
  logic                         m_axis_dma_write_desc_ready;

  logic [REQ_TAG_WIDTH-1:0]     s_axis_dma_write_desc_status_tag;
  logic                         s_axis_dma_write_desc_status_error;
  logic                         s_axis_dma_write_desc_status_valid;

  modport master (
    input  s_axis_req_sel, s_axis_req_queue, s_axis_req_tag, s_axis_req_data, s_axis_req_valid,
    output s_axis_req_ready,
    output m_axis_req_status_tag, m_axis_req_status_full, m_axis_req_status_error, m_axis_req_status_valid,
    output m_axis_cpl_enqueue_req_sel, m_axis_cpl_enqueue_req_queue, m_axis_cpl_enqueue_req_tag,
    output m_axis_cpl_enqueue_req_valid,
    input  m_axis_cpl_enqueue_req_ready,
    input  s_axis_cpl_enqueue_resp_addr, s_axis_cpl_enqueue_resp_tag, s_axis_cpl_enqueue_resp_op_tag,
    input  s_axis_cpl_enqueue_resp_full, s_axis_cpl_enqueue_resp_error, s_axis_cpl_enqueue_resp_valid,
    output s_axis_cpl_enqueue_resp_ready,
    output m_axis_cpl_enqueue_commit_op_tag, m_axis_cpl_enqueue_commit_valid,
    input  m_axis_cpl_enqueue_commit_ready,
    output m_axis_dma_write_desc_addr, m_axis_dma_write_desc_data, m_axis_dma_write_desc_tag,
    output m_axis_dma_write_desc_valid,
    input  m_axis_dma_write_desc_ready,
    input  s_axis_dma_write_desc_status_tag, s_axis_dma_write_desc_status_error,
    input  s_axis_dma_write_desc_status_valid
  );

  modport slave (
    output s_axis_req_sel, s_axis_req_queue, s_axis_req_tag, s_axis_req_data, s_axis_req_valid,
    input  s_axis_req_ready,
    input  m_axis_req_status_tag, m_axis_req_status_full, m_axis_req_status_error, m_axis_req_status_valid,
    input  m_axis_cpl_enqueue_req_sel, m_axis_cpl_enqueue_req_queue, m_axis_cpl_enqueue_req_tag,
    input  m_axis_cpl_enqueue_req_valid,
    output m_axis_cpl_enqueue_req_ready,
    output s_axis_cpl_enqueue_resp_addr, s_axis_cpl_enqueue_resp_tag, s_axis_cpl_enqueue_resp_op_tag,
    output s_axis_cpl_enqueue_resp_full, s_axis_cpl_enqueue_resp_error, s_axis_cpl_enqueue_resp_valid,
    input  s_axis_cpl_enqueue_resp_ready,
    input  m_axis_cpl_enqueue_commit_op_tag, m_axis_cpl_enqueue_commit_valid,
    output m_axis_cpl_enqueue_commit_ready,
    input  m_axis_dma_write_desc_addr, m_axis_dma_write_desc_data, m_axis_dma_write_desc_tag,
    input  m_axis_dma_write_desc_valid,
    output m_axis_dma_write_desc_ready,
    output s_axis_dma_write_desc_status_tag, s_axis_dma_write_desc_status_error,
    output s_axis_dma_write_desc_status_valid
  );
endinterface

// File: rtl/cpl_write_engine.sv
// Single-outstanding completion write engine: reserve a queue slot, DMA the record
// to host memory, commit the slot, then return one status pulse per accepted request.
module cpl_write_engine #(
  parameter int SELECT_WIDTH      = 2,
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int REQ_TAG_WIDTH     = 7,
  parameter int OP_TAG_WIDTH      = 8,
  parameter int DMA_ADDR_WIDTH    = 64,
  parameter int CPL_SIZE          = 32
) (
  input logic                clk,
  input logic                rst_n,
  cpl_write_engine_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ENQ_REQ,
    ENQ_RESP,
    DMA_REQ,
    DMA_WAIT,
    COMMIT,
    STATUS
  } state_t;

  state_t state;

  logic req_ready;
  logic enq_req_valid;
  logic enq_resp_ready;
  logic dma_desc_valid;
  logic commit_valid;
  logic status_valid;
  logic status_full;
  logic status_error;

  logic [SELECT_WIDTH-1:0]      sel_q;
  logic [QUEUE_INDEX_WIDTH-1:0] queue_q;
  logic [REQ_TAG_WIDTH-1:0]     tag_q;
  logic [CPL_SIZE*8-1:0]        data_q;
  logic [DMA_ADDR_WIDTH-1:0]    addr_q;
  logic [OP_TAG_WIDTH-1:0]      op_tag_q;

  // The queue manager echoes our request tag, but with one request in flight it carries no information.
  logic unused_resp_tag;
  assign unused_resp_tag = ^bus.s_axis_cpl_enqueue_resp_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      enq_req_valid  <= 1'b0;
      enq_resp_ready <= 1'b0;
      dma_desc_valid <= 1'b0;
      commit_valid   <= 1'b0;
      status_valid   <= 1'b0;
      status_full    <= 1'b0;
      status_error   <= 1'b0;
      sel_q          <= '0;
      queue_q        <= '0;
      tag_q          <= '0;
      data_q         <= '0;
      addr_q         <= '0;
      op_tag_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && bus.s_axis_req_valid) begin
            sel_q         <= bus.s_axis_req_sel;
            queue_q       <= bus.s_axis_req_queue;
            tag_q         <= bus.s_axis_req_tag;
            data_q        <= bus.s_axis_req_data;
            status_full   <= 1'b0;
            status_error  <= 1'b0;
            req_ready     <= 1'b0;
            enq_req_valid <= 1'b1;
            state         <= ENQ_REQ;
          end
        end
        ENQ_REQ: begin
          if (bus.m_axis_cpl_enqueue_req_ready) begin
            enq_req_valid  <= 1'b0;
            enq_resp_ready <= 1'b1;
            state          <= ENQ_RESP;
          end
        end
        ENQ_RESP: begin
          if (bus.s_axis_cpl_enqueue_resp_valid) begin
            enq_resp_ready <= 1'b0;
            addr_q         <= bus.s_axis_cpl_enqueue_resp_addr;
            op_tag_q       <= bus.s_axis_cpl_enqueue_resp_op_tag;
            // An error means no slot was reserved, so it outranks a simultaneous full flag.
            if (bus.s_axis_cpl_enqueue_resp_error) begin
              status_full  <= 1'b0;
              status_error <= 1'b1;
              state        <= STATUS;
            end else if (bus.s_axis_cpl_enqueue_resp_full) begin
              status_full  <= 1'b1;
              status_error <= 1'b0;
              state        <= STATUS;
            end else begin
              dma_desc_valid <= 1'b1;
              state          <= DMA_REQ;
            end
          end
        end
        DMA_REQ: begin
          if (bus.m_axis_dma_write_desc_ready) begin
            dma_desc_valid <= 1'b0;
            state          <= DMA_WAIT;
          end
        end
        DMA_WAIT: begin
          if (bus.s_axis_dma_write_desc_status_valid &&
              bus.s_axis_dma_write_desc_status_tag == tag_q) begin
            status_full  <= 1'b0;
            status_error <= bus.s_axis_dma_write_desc_status_error;
            commit_valid <= 1'b1;
            state        <= COMMIT;
          end
        end
        COMMIT: begin
          if (bus.m_axis_cpl_enqueue_commit_ready) begin
            commit_valid <= 1'b0;
            state        <= STATUS;
          end
        end
        STATUS: begin
          // First cycle raises the pulse, second drops it and reopens the request port.
          if (!status_valid) begin
            status_valid <= 1'b1;
          end else begin
            status_valid <= 1'b0;
            req_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_axis_req_ready                 = req_ready;
  assign bus.m_axis_req_status_tag            = tag_q;
  assign bus.m_axis_req_status_full           = status_full;
  assign bus.m_axis_req_status_error          = status_error;
  assign bus.m_axis_req_status_valid          = status_valid;
  assign bus.m_axis_cpl_enqueue_req_sel       = sel_q;
  assign bus.m_axis_cpl_enqueue_req_queue     = queue_q;
  assign bus.m_axis_cpl_enqueue_req_tag       = tag_q;
  assign bus.m_axis_cpl_enqueue_req_valid     = enq_req_valid;
  assign bus.s_axis_cpl_enqueue_resp_ready    = enq_resp_ready;
  assign bus.m_axis_cpl_enqueue_commit_op_tag = op_tag_q;
  assign bus.m_axis_cpl_enqueue_commit_valid  = commit_valid;
  assign bus.m_axis_dma_write_desc_addr       = addr_q;
  assign bus.m_axis_dma_write_desc_data       = data_q;
  assign bus.m_axis_dma_write_desc_tag        = tag_q;
  assign bus.m_axis_dma_write_desc_valid      = dma_desc_valid;

endmodule

// File: tb/tb_cpl_write_engine.sv
// Directed bench for cpl_write_engine: stimulus is driven on the falling edge and
// outputs are checked there against hand-computed cycle-exact expectations.
module tb_cpl_write_engine;
  localparam int SW = 2;
  localparam int QW = 13;
  localparam int TW = 7;
  localparam int OW = 8;
  localparam int AW = 64;
  localparam int CS = 32;
  localparam int DW = CS * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cpl_write_engine_if #(.SELECT_WIDTH(SW), .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW),
                        .OP_TAG_WIDTH(OW), .DMA_ADDR_WIDTH(AW), .CPL_SIZE(CS)) bus ();

  cpl_write_engine #(.SELECT_WIDTH(SW), .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW),
                     .OP_TAG_WIDTH(OW), .DMA_ADDR_WIDTH(AW), .CPL_SIZE(CS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int dma_cnt = 0;
  int commit_cnt = 0;
  int status_cnt = 0;

  // Transfer counters let each scenario prove that a DMA, commit or status did or did not happen.
  always @(posedge clk) begin
    if (bus.m_axis_dma_write_desc_valid && bus.m_axis_dma_write_desc_ready) dma_cnt <= dma_cnt + 1;
    if (bus.m_axis_cpl_enqueue_commit_valid && bus.m_axis_cpl_enqueue_commit_ready) commit_cnt <= commit_cnt + 1;
    if (bus.m_axis_req_status_valid) status_cnt <= status_cnt + 1;
  end

  // Order: req_ready, enq_req_valid, enq_resp_ready, dma_desc_valid, commit_valid, status_valid.
  function automatic logic [5:0] valids();
    return {bus.s_axis_req_ready, bus.m_axis_cpl_enqueue_req_valid, bus.s_axis_cpl_enqueue_resp_ready,
            bus.m_axis_dma_write_desc_valid, bus.m_axis_cpl_enqueue_commit_valid, bus.m_axis_req_status_valid};
  endfunction

  task automatic set_readys(input logic enq, input logic dma, input logic cmt);
    bus.m_axis_cpl_enqueue_req_ready    = enq;
    bus.m_axis_dma_write_desc_ready     = dma;
    bus.m_axis_cpl_enqueue_commit_ready = cmt;
  endtask

  task automatic drive_req(input logic [SW-1:0] sel, input logic [QW-1:0] queue,
                           input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bus.s_axis_req_sel   = sel;
    bus.s_axis_req_queue = queue;
    bus.s_axis_req_tag   = tag;
    bus.s_axis_req_data  = data;
    bus.s_axis_req_valid = 1'b1;
  endtask

  task automatic drive_resp(input logic [AW-1:0] addr, input logic [TW-1:0] tag, input logic [OW-1:0] op_tag,
                            input logic full, input logic error);
    bus.s_axis_cpl_enqueue_resp_addr   = addr;
    bus.s_axis_cpl_enqueue_resp_tag    = tag;
    bus.s_axis_cpl_enqueue_resp_op_tag = op_tag;
    bus.s_axis_cpl_enqueue_resp_full   = full;
    bus.s_axis_cpl_enqueue_resp_error  = error;
    bus.s_axis_cpl_enqueue_resp_valid  = 1'b1;
  endtask

  task automatic drive_dma_status(input logic [TW-1:0] tag, input logic error);
    bus.s_axis_dma_write_desc_status_tag   = tag;
    bus.s_axis_dma_write_desc_status_error = error;
    bus.s_axis_dma_write_desc_status_valid = 1'b1;
  endtask

  task automatic test_reset();
    bus.s_axis_req_valid = 1'b0;
    bus.s_axis_cpl_enqueue_resp_valid = 1'b0;
    bus.s_axis_dma_write_desc_status_valid = 1'b0;
    drive_req('0, '0, '0, '0);
    bus.s_axis_req_valid = 1'b0;
    set_readys(1'b1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (valids() !== 6'b000000) begin
      miscompares++; $display("[TB] FAIL reset_valids: got %b expected %b", valids(), 6'b000000);
    end
    vectors++;
    if ({bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_status: got %h expected 0",
        {bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error});
    end
    vectors++;
    if ({bus.m_axis_dma_write_desc_addr, bus.m_axis_dma_write_desc_data, bus.m_axis_cpl_enqueue_commit_op_tag,
         bus.m_axis_cpl_enqueue_req_queue} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_payload: got addr %h op_tag %h queue %h expected 0",
        bus.m_axis_dma_write_desc_addr, bus.m_axis_cpl_enqueue_commit_op_tag, bus.m_axis_cpl_enqueue_req_queue);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b100000) begin
      miscompares++; $display("[TB] FAIL reset_release_ready: got %b expected %b", valids(), 6'b100000);
    end
  endtask

  task automatic test_normal(input logic [SW-1:0] sel, input logic [QW-1:0] queue, input logic [TW-1:0] tag,
                             input logic [DW-1:0] data, input logic [AW-1:0] addr, input logic [OW-1:0] op_tag);
    int dma0, cmt0, sts0;
    dma0 = dma_cnt; cmt0 = commit_cnt; sts0 = status_cnt;
    set_readys(1'b1, 1'b1, 1'b1);
    drive_req(sel, queue, tag, data);
    @(negedge clk);
    bus.s_axis_req_valid = 1'b0;
    vectors++;
    if (valids() !== 6'b010000) begin
      miscompares++; $display("[TB] FAIL normal_enq_valids: got %b expected %b", valids(), 6'b010000);
    end
    vectors++;
    if ({bus.m_axis_cpl_enqueue_req_sel, bus.m_axis_cpl_enqueue_req_queue, bus.m_axis_cpl_enqueue_req_tag}
        !== {sel, queue, tag}) begin
      miscompares++; $display("[TB] FAIL normal_enq_fields: got %h %h %h expected %h %h %h",
        bus.m_axis_cpl_enqueue_req_sel, bus.m_axis_cpl_enqueue_req_queue, bus.m_axis_cpl_enqueue_req_tag,
        sel, queue, tag);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b001000) begin
      miscompares++; $display("[TB] FAIL normal_resp_ready: got %b expected %b", valids(), 6'b001000);
    end
    drive_resp(addr, tag, op_tag, 1'b0, 1'b0);
    @(negedge clk);
    bus.s_axis_cpl_enqueue_resp_valid = 1'b0;
    vectors++;
    if (valids() !== 6'b000100) begin
      miscompares++; $display("[TB] FAIL normal_dma_valid: got %b expected %b", valids(), 6'b000100);
    end
    vectors++;
    if ({bus.m_axis_dma_write_desc_addr, bus.m_axis_dma_write_desc_tag, bus.m_axis_dma_write_desc_data}
        !== {addr, tag, data}) begin
      miscompares++; $display("[TB] FAIL normal_dma_desc: got addr %h tag %h data %h expected %h %h %h",
        bus.m_axis_dma_write_desc_addr, bus.m_axis_dma_write_desc_tag, bus.m_axis_dma_write_desc_data,
        addr, tag, data);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000000) begin
      miscompares++; $display("[TB] FAIL normal_dma_wait: got %b expected %b", valids(), 6'b000000);
    end
    drive_dma_status(tag, 1'b0);
    @(negedge clk);
    bus.s_axis_dma_write_desc_status_valid = 1'b0;
    vectors++;
    if (valids() !== 6'b000010 || bus.m_axis_cpl_enqueue_commit_op_tag !== op_tag) begin
      miscompares++; $display("[TB] FAIL normal_commit: got %b op_tag %h expected %b op_tag %h",
        valids(), bus.m_axis_cpl_enqueue_commit_op_tag, 6'b000010, op_tag);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000000) begin
      miscompares++; $display("[TB] FAIL normal_pre_status: got %b expected %b", valids(), 6'b000000);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000001 ||
        {bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error} !== {tag, 2'b00}) begin
      miscompares++; $display("[TB] FAIL normal_status: got %b tag %h full %b error %b expected %b tag %h 0 0",
        valids(), bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error,
        6'b000001, tag);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b100000 || dma_cnt - dma0 != 1 || commit_cnt - cmt0 != 1 || status_cnt - sts0 != 1) begin
      miscompares++; $display("[TB] FAIL normal_end: got %b dma %0d commit %0d status %0d expected %b 1 1 1",
        valids(), dma_cnt - dma0, commit_cnt - cmt0, status_cnt - sts0, 6'b100000);
    end
  endtask

  task automatic test_enq_reject(input string name, input logic [TW-1:0] tag, input logic [QW-1:0] queue,
                                 input logic resp_full, input logic resp_error,
                                 input logic exp_full, input logic exp_error);
    int dma0, cmt0, sts0;
    dma0 = dma_cnt; cmt0 = commit_cnt; sts0 = status_cnt;
    set_readys(1'b1, 1'b1, 1'b1);
    drive_req(2'd2, queue, tag, {8{32'hDEAD_BEEF}});
    @(negedge clk);
    bus.s_axis_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b001000) begin
      miscompares++; $display("[TB] FAIL %s_resp_ready: got %b expected %b", name, valids(), 6'b001000);
    end
    drive_resp(64'h0000_0000_2000_0040, tag, 8'h7E, resp_full, resp_error);
    @(negedge clk);
    bus.s_axis_cpl_enqueue_resp_valid = 1'b0;
    vectors++;
    if (valids() !== 6'b000000) begin
      miscompares++; $display("[TB] FAIL %s_no_dma: got %b expected %b", name, valids(), 6'b000000);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000001 ||
        {bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error}
        !== {tag, exp_full, exp_error}) begin
      miscompares++; $display("[TB] FAIL %s_status: got %b tag %h full %b error %b expected %b tag %h full %b error %b",
        name, valids(), bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error,
        6'b000001, tag, exp_full, exp_error);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b100000 || dma_cnt - dma0 != 0 || commit_cnt - cmt0 != 0 || status_cnt - sts0 != 1) begin
      miscompares++; $display("[TB] FAIL %s_end: got %b dma %0d commit %0d status %0d expected %b 0 0 1",
        name, valids(), dma_cnt - dma0, commit_cnt - cmt0, status_cnt - sts0, 6'b100000);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] data;
    data = {16{16'hA55A}};
    set_readys(1'b0, 1'b0, 1'b0);
    drive_req(2'd3, 13'h100, 7'h4C, data);
    @(negedge clk);
    bus.s_axis_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (valids() !== 6'b010000 || bus.m_axis_cpl_enqueue_req_queue !== 13'h100 ||
          bus.m_axis_cpl_enqueue_req_tag !== 7'h4C) begin
        miscompares++; $display("[TB] FAIL bp_enq_hold[%0d]: got %b queue %h tag %h expected %b 100 4c",
          i, valids(), bus.m_axis_cpl_enqueue_req_queue, bus.m_axis_cpl_enqueue_req_tag, 6'b010000);
      end
      @(negedge clk);
    end
    bus.m_axis_cpl_enqueue_req_ready = 1'b1;
    @(negedge clk);
    drive_resp(64'hFFFF_FFFF_FFFF_FFE0, 7'h4C, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    bus.s_axis_cpl_enqueue_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (valids() !== 6'b000100 || bus.m_axis_dma_write_desc_addr !== 64'hFFFF_FFFF_FFFF_FFE0 ||
          bus.m_axis_dma_write_desc_data !== data) begin
        miscompares++; $display("[TB] FAIL bp_dma_hold[%0d]: got %b addr %h data %h expected %b ffffffffffffffe0 %h",
          i, valids(), bus.m_axis_dma_write_desc_addr, bus.m_axis_dma_write_desc_data, 6'b000100, data);
      end
      @(negedge clk);
    end
    bus.m_axis_dma_write_desc_ready = 1'b1;
    @(negedge clk);
    drive_dma_status(7'h4C, 1'b0);
    @(negedge clk);
    bus.s_axis_dma_write_desc_status_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (valids() !== 6'b000010 || bus.m_axis_cpl_enqueue_commit_op_tag !== 8'hFF) begin
        miscompares++; $display("[TB] FAIL bp_commit_hold[%0d]: got %b op_tag %h expected %b ff",
          i, valids(), bus.m_axis_cpl_enqueue_commit_op_tag, 6'b000010);
      end
      @(negedge clk);
    end
    bus.m_axis_cpl_enqueue_commit_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000001 ||
        {bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error} !== {7'h4C, 2'b00}) begin
      miscompares++; $display("[TB] FAIL bp_status: got %b tag %h full %b error %b expected %b tag 4c 0 0",
        valids(), bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error, 6'b000001);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b100000) begin
      miscompares++; $display("[TB] FAIL bp_end: got %b expected %b", valids(), 6'b100000);
    end
  endtask

  task automatic test_dma_filter();
    int cmt0;
    cmt0 = commit_cnt;
    set_readys(1'b1, 1'b1, 1'b1);
    drive_req(2'd0, 13'h0F0, 7'h2A, {32{8'h5C}});
    @(negedge clk);
    bus.s_axis_req_valid = 1'b0;
    @(negedge clk);
    drive_resp(64'h0000_0001_0000_0000, 7'h2A, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    bus.s_axis_cpl_enqueue_resp_valid = 1'b0;
    // Matching status coincident with the descriptor handshake must not be captured.
    drive_dma_status(7'h2A, 1'b0);
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000000) begin
      miscompares++; $display("[TB] FAIL filter_same_cycle: got %b expected %b", valids(), 6'b000000);
    end
    drive_dma_status(7'h11, 1'b1);
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000000) begin
      miscompares++; $display("[TB] FAIL filter_wrong_tag: got %b expected %b", valids(), 6'b000000);
    end
    drive_dma_status(7'h2A, 1'b1);
    @(negedge clk);
    bus.s_axis_dma_write_desc_status_valid = 1'b0;
    vectors++;
    if (valids() !== 6'b000010 || bus.m_axis_cpl_enqueue_commit_op_tag !== 8'h10) begin
      miscompares++; $display("[TB] FAIL filter_commit: got %b op_tag %h expected %b op_tag 10",
        valids(), bus.m_axis_cpl_enqueue_commit_op_tag, 6'b000010);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b000001 ||
        {bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error} !== {7'h2A, 2'b01}) begin
      miscompares++; $display("[TB] FAIL filter_status: got %b tag %h full %b error %b expected %b tag 2a 0 1",
        valids(), bus.m_axis_req_status_tag, bus.m_axis_req_status_full, bus.m_axis_req_status_error, 6'b000001);
    end
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b100000 || commit_cnt - cmt0 != 1) begin
      miscompares++; $display("[TB] FAIL filter_end: got %b commits %0d expected %b 1",
        valids(), commit_cnt - cmt0, 6'b100000);
    end
  endtask

  task automatic test_reset_mid_op();
    int cmt0, sts0;
    cmt0 = commit_cnt; sts0 = status_cnt;
    set_readys(1'b1, 1'b1, 1'b1);
    drive_req(2'd1, 13'h077, 7'h5D, {32{8'h99}});
    @(negedge clk);
    bus.s_axis_req_valid = 1'b0;
    @(negedge clk);
    drive_resp(64'h0000_0000_3000_0000, 7'h5D, 8'h21, 1'b0, 1'b0);
    @(negedge clk);
    bus.s_axis_cpl_enqueue_resp_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (valids() !== 6'b000000 || bus.m_axis_dma_write_desc_addr !== '0) begin
      miscompares++; $display("[TB] FAIL midreset_async: got %b addr %h expected %b addr 0",
        valids(), bus.m_axis_dma_write_desc_addr, 6'b000000);
    end
    drive_dma_status(7'h5D, 1'b0);
    repeat (2) @(negedge clk);
    bus.s_axis_dma_write_desc_status_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (valids() !== 6'b100000 || commit_cnt - cmt0 != 0 || status_cnt - sts0 != 0) begin
      miscompares++; $display("[TB] FAIL midreset_release: got %b commits %0d status %0d expected %b 0 0",
        valids(), commit_cnt - cmt0, status_cnt - sts0, 6'b100000);
    end
    test_normal(2'd2, 13'h1FFF, 7'h7F, {8{32'h0123_4567}}, 64'h8000_0000_0000_0020, 8'hC3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_normal(2'd1, 13'h005, 7'h2A, {32{8'h11}}, 64'h0000_0000_1000_0000, 8'h03);
    test_enq_reject("queue_full", 7'h33, 13'h0AA, 1'b1, 1'b0, 1'b1, 1'b0);
    test_enq_reject("enq_error", 7'h34, 13'h0AB, 1'b1, 1'b1, 1'b0, 1'b1);
    test_backpressure();
    test_dma_filter();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
